// File: rtl/vlan_remover.sv
// vlan_remover: egress 802.1Q tag stripper.
// A fallthrough FIFO buffers the input stream. On the first beat of each packet
// a tag at bytes 12-15 is detected. Tagged packets have those 4 bytes removed,
// every following beat is shifted down by 4 bytes, and the tuser length drops by 4.
// Untagged packets pass through unchanged. The outputs are driven
// combinationally from the FIFO head and the 224-bit residual register.
module vlan_remover #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_BITS      = 2
) (
  input  logic                               axis_aclk,
  input  logic                               axis_reset,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic                               s_axis_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,

  output logic [11:0]                        last_vid,
  output logic [31:0]                        tagged_pkts,
  output logic [31:0]                        untagged_pkts
);

  localparam int DW     = C_S_AXIS_DATA_WIDTH;
  localparam int KW     = DW / 8;
  localparam int UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int RES_W  = DW - 32;
  localparam int RES_KW = KW - 4;
  localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
  localparam int CNT_W  = FIFO_DEPTH_BITS + 1;

  typedef enum logic [1:0] {
    S_HEADER,
    S_PASS,
    S_STRIP,
    S_FLUSH
  } state_t;

  // ---------------------------------------------------------------------------
  // Input fallthrough FIFO
  // ---------------------------------------------------------------------------
  logic [DW-1:0]              r_mem_data [DEPTH];
  logic [KW-1:0]              r_mem_keep [DEPTH];
  logic [UW-1:0]              r_mem_user [DEPTH];
  logic                       r_mem_last [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
  logic [CNT_W-1:0]           r_count;

  logic                       w_wr;
  logic                       w_pop;
  logic                       w_empty;
  logic                       w_nearly_full;
  logic [DW-1:0]              w_head_data;
  logic [KW-1:0]              w_head_keep;
  logic [UW-1:0]              w_head_user;
  logic                       w_head_last;

  assign w_empty       = (r_count == '0);
  assign w_nearly_full = (r_count >= CNT_W'(DEPTH - 1));
  assign s_axis_tready = !w_nearly_full;
  assign w_wr          = s_axis_tvalid && s_axis_tready;

  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_head_keep = r_mem_keep[r_rd_ptr];
  assign w_head_user = r_mem_user[r_rd_ptr];
  assign w_head_last = r_mem_last[r_rd_ptr];

  // FIFO storage: written on every accepted input beat
  always_ff @(posedge axis_aclk) begin
    if (w_wr) begin
      r_mem_data[r_wr_ptr] <= s_axis_tdata;
      r_mem_keep[r_wr_ptr] <= s_axis_tkeep;
      r_mem_user[r_wr_ptr] <= s_axis_tuser;
      r_mem_last[r_wr_ptr] <= s_axis_tlast;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_BITS'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_BITS'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Strip FSM
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [RES_W-1:0]    r_res;
  logic [RES_KW-1:0]   r_res_keep;
  logic [UW-1:0]       r_ru;
  logic                r_first;
  logic [11:0]         r_last_vid;
  logic [31:0]         r_tagged;
  logic [31:0]         r_untagged;

  logic                w_tagged;
  logic                w_strip_end;
  logic                w_out_valid;
  logic [DW-1:0]       w_out_data;
  logic [KW-1:0]       w_out_keep;
  logic [UW-1:0]       w_out_user;
  logic                w_out_last;

  assign w_tagged    = (w_head_data[111:96] == 16'h0081);
  // The final input beat fits entirely into the current output beat.
  assign w_strip_end = (w_head_keep[KW-1:4] == '0);

  // Output beat and FIFO pop selection for the current state
  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = '0;
    w_out_keep  = '0;
    w_out_user  = '0;
    w_out_last  = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_HEADER: begin
        w_pop = !w_empty && w_tagged;
      end
      S_PASS: begin
        w_out_valid = !w_empty;
        w_out_data  = w_head_data;
        w_out_keep  = w_head_keep;
        w_out_user  = w_head_user;
        w_out_last  = w_head_last;
        w_pop       = !w_empty && m_axis_tready;
      end
      S_STRIP: begin
        w_out_valid = !w_empty;
        w_out_data  = {w_head_data[31:0], r_res};
        w_out_keep  = {w_head_keep[3:0], r_res_keep};
        w_out_user  = r_first ? r_ru : w_head_user;
        w_out_last  = w_head_last && w_strip_end;
        w_pop       = !w_empty && m_axis_tready;
      end
      S_FLUSH: begin
        w_out_valid = 1'b1;
        w_out_data  = {32'd0, r_res};
        w_out_keep  = {4'd0, r_res_keep};
        w_out_user  = r_ru;
        w_out_last  = 1'b1;
      end
      default: begin
        w_pop = 1'b0;
      end
    endcase
    // Idle and reset cycles present an all-zero bus.
    if (axis_reset || !w_out_valid) begin
      w_out_valid = 1'b0;
      w_out_data  = '0;
      w_out_keep  = '0;
      w_out_user  = '0;
      w_out_last  = 1'b0;
    end
  end

  // State, residual, captured VID and packet counters
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      r_state    <= S_HEADER;
      r_res      <= '0;
      r_res_keep <= '0;
      r_ru       <= '0;
      r_first    <= 1'b0;
      r_last_vid <= '0;
      r_tagged   <= '0;
      r_untagged <= '0;
    end else begin
      case (r_state)
        S_HEADER: begin
          if (!w_empty) begin
            if (w_tagged) begin
              r_res      <= {w_head_data[DW-1:128], w_head_data[95:0]};
              r_res_keep <= {w_head_keep[KW-1:16], w_head_keep[11:0]};
              r_ru       <= {w_head_user[UW-1:16], w_head_user[15:0] - 16'd4};
              r_first    <= 1'b1;
              r_last_vid <= {w_head_data[115:112], w_head_data[127:120]};
              r_tagged   <= r_tagged + 32'd1;
              r_state    <= w_head_last ? S_FLUSH : S_STRIP;
            end else begin
              r_untagged <= r_untagged + 32'd1;
              r_state    <= S_PASS;
            end
          end
        end
        S_PASS: begin
          if (!w_empty && m_axis_tready && w_head_last) begin
            r_state <= S_HEADER;
          end
        end
        S_STRIP: begin
          if (!w_empty && m_axis_tready) begin
            r_res      <= w_head_data[DW-1:32];
            r_res_keep <= w_head_keep[KW-1:4];
            r_ru       <= w_head_user;
            r_first    <= 1'b0;
            if (w_head_last) begin
              if (w_strip_end) begin
                r_res      <= '0;
                r_res_keep <= '0;
                r_state    <= S_HEADER;
              end else begin
                r_state <= S_FLUSH;
              end
            end
          end
        end
        S_FLUSH: begin
          if (m_axis_tready) begin
            r_res      <= '0;
            r_res_keep <= '0;
            r_state    <= S_HEADER;
          end
        end
        default: begin
          r_state <= S_HEADER;
        end
      endcase
    end
  end

  assign m_axis_tvalid = w_out_valid;
  assign m_axis_tdata  = w_out_data;
  assign m_axis_tkeep  = w_out_keep;
  assign m_axis_tuser  = w_out_user;
  assign m_axis_tlast  = w_out_last;

  assign last_vid      = r_last_vid;
  assign tagged_pkts   = r_tagged;
  assign untagged_pkts = r_untagged;

endmodule

// File: doc/vlan_remover.md
Name: vlan_remover

Overview:
- Egress-side companion to the VLAN insertion stage. Placed after the output port lookup and before the output queues.
- Detects an 802.1Q tag at bytes 12-15 of each AXI4-Stream packet, strips it, realigns all following beats down by 4 bytes, and decrements the tuser length field by 4.
- Untagged packets pass through unmodified.
- Exposes the stripped VLAN ID and per-class packet counters as status ports.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256: master data width. Only 256 is supported.
- C_S_AXIS_DATA_WIDTH, 256: slave data width. Must equal the master width.
- C_M_AXIS_TUSER_WIDTH, 128: master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128: slave tuser width.
- FIFO_DEPTH_BITS, 2: log2 depth of the input fallthrough FIFO.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_reset  in  1  reset, synchronous and active-high.
- s_axis_tdata  in  256  input data; byte 0 is at [7:0].
- s_axis_tkeep  in  32  input byte enables, contiguous from the LSB.
- s_axis_tuser  in  128  input metadata; [15:0] is the length in bytes, [23:16] src port, [31:24] dst port.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready; equals !fifo_nearly_full.
- s_axis_tlast  in  1  input end of packet.
- m_axis_tdata  out  256  output data.
- m_axis_tkeep  out  32  output byte enables.
- m_axis_tuser  out  128  output metadata.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of packet.
- last_vid  out  12  VID of the most recently stripped tag.
- tagged_pkts  out  32  count of stripped packets.
- untagged_pkts  out  32  count of passed-through packets.

Behaviour:
Reset:
- While axis_reset=1 at a clock edge, all state resets: FSM to HEADER, FIFO empty, residual cleared, counters 0, last_vid 0.
- Outputs during and after reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0.
- Reset mid-packet discards the partial packet. No tlast is emitted for it.

Input buffering and handshake:
- Input goes through a fallthrough FIFO with depth 2^FIFO_DEPTH_BITS.
- A write occurs on s_axis_tvalid & s_axis_tready.
- m_axis_tvalid never depends on m_axis_tready.
- While tvalid=1 and tready=0, m_axis_tdata/tkeep/tuser/tlast hold stable.

Tag detection:
- Evaluated on the first beat of each packet only.
- tagged = (tdata[111:96]==16'h0081), i.e. byte12=0x81 and byte13=0x00.
- TCI = {tdata[119:112], tdata[127:120]}; VID = TCI[11:0].

FSM states:
- HEADER: waits for a FIFO beat.
  - Untagged: go to PASS without popping; untagged_pkts+1.
  - Tagged: pop the beat and load residual R = {d[255:128], d[95:0]} (224 bits), RK = {k[31:16], k[11:0]}, RU = tuser with [15:0]-16'd4 (modulo 2^16).
  - Tagged: capture last_vid=VID and increment tagged_pkts.
  - Tagged with tlast on the first beat: go to FLUSH. Otherwise go to STRIP.
- PASS: output equals the FIFO head; pop on m_axis_tvalid & m_axis_tready. Return to HEADER after the beat with tlast is accepted.
- STRIP: valid when the FIFO is non-empty (next beat N).
  - Output data = {N.d[31:0], R}.
  - Output keep = {N.k[3:0], RK}.
  - Output tuser = RU on the first output beat, N.tuser thereafter.
  - On accept: pop N, then R = N.d[255:32], RK = N.k[31:4].
  - N.tlast with N.k[31:4]==0: drive tlast=1 on this beat, go to HEADER.
  - N.tlast with N.k[31:4]!=0: drive tlast=0, go to FLUSH.
- FLUSH: output {32'd0, R}, keep {4'd0, RK}, tlast=1, valid=1. On accept, clear the residual and go to HEADER.

Latency and throughput:
- Combinational from the FIFO head: PASS adds 0 cycles beyond the FIFO; the first tagged output beat appears when beat 2 is at the FIFO head.
- Sustained throughput is 1 beat/cycle. FLUSH adds at most one extra beat per packet.

Counters: 32-bit, wrap 0xFFFFFFFF->0, no saturation.

Test Plan:
- Untagged 64B packet (2 full beats, tuser[15:0]=64, byte12=0x08): output is bit-identical, 2 beats, untagged_pkts=1, tagged_pkts=0.
- Tagged 68B packet (beat0 keep 0xFFFFFFFF, beat1 full, beat2 keep 0xF), TCI=0x0064, tuser len 68:
  - Output is 64B in 2 beats; last keep 0xFFFFFFFF with tlast.
  - tuser[15:0]=64, bytes 12-13 equal input bytes 16-17, last_vid=0x064.
- Tagged 96B packet (3 full beats): 3 output beats; beat 3 keep 0x0FFFFFFF with tlast (FLUSH path); tuser len 92.
- Tagged single-beat 32B packet with tlast: one output beat, keep 0x0FFFFFFF, tlast=1, len 28.
- Backpressure: m_axis_tready toggles every cycle on alternating tagged/untagged packets:
  - no beat is lost or duplicated; data is stable while stalled;
  - s_axis_tready drops when the FIFO is nearly full.
- Reset asserted mid-STRIP for 1 cycle, then an untagged packet: tvalid=0 during reset, no stale residual, the clean packet passes, and the counters restart from 0.
